exec_controller: RTL and testbench

EXEC_CONTROLLER -- requirements
Module: exec_controller

---
 rtl/exec_controller.sv | 141 ++++++++++++++
 tb/tb_exec_controller.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_controller.sv
// Pipeline execution controller: free-run, single-step and breakpoint-with-drain
// sequencing for a fetch/decode pipeline. All outputs come straight from flops.
module exec_controller #(
    parameter int unsigned DRAIN_DEPTH = 4,
    parameter int unsigned CC_WIDTH    = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                go,
    input  logic                step,
    input  logic                tick,
    input  logic                halt_req,
    input  logic [15:0]         pc,
    input  logic [15:0]         bp_addr,
    input  logic                bp_en,
    output logic                pipe_en,
    output logic                fetch_hold,
    output logic                halted,
    output logic                bp_hit,
    output logic [1:0]          state,
    output logic [CC_WIDTH-1:0] cc
);

    localparam int unsigned DC_W = (DRAIN_DEPTH == 0) ? 1 : $clog2(DRAIN_DEPTH + 1);

    localparam logic [1:0] S_HALT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_STEP  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]          state_q, state_d;
    logic                pipe_en_q, pipe_en_d;
    logic                fetch_hold_q, fetch_hold_d;
    logic                halted_q, halted_d;
    logic                bp_hit_q, bp_hit_d;
    logic                skip_bp_q, skip_bp_d;
    logic [DC_W-1:0]     drain_q, drain_d;
    logic [CC_WIDTH-1:0] cc_q, cc_d;
    logic                bp_match;
    logic                last_drain_adv;

    // skip_bp masks the compare until the resume instruction has actually advanced
    assign bp_match = bp_en && (pc == bp_addr) && !skip_bp_q;

    always_comb begin
        state_d        = state_q;
        pipe_en_d      = 1'b0;
        bp_hit_d       = bp_hit_q;
        skip_bp_d      = skip_bp_q & ~pipe_en_q;
        drain_d        = drain_q;
        cc_d           = cc_q + CC_WIDTH'(pipe_en_q);
        last_drain_adv = 1'b0;

        case (state_q)
            S_HALT: begin
                if (go) begin
                    state_d   = S_RUN;
                    skip_bp_d = 1'b1;
                    bp_hit_d  = 1'b0;
                end else if (step) begin
                    state_d   = S_STEP;
                    pipe_en_d = 1'b1;
                    skip_bp_d = 1'b1;
                    bp_hit_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (halt_req || !go) begin
                    state_d = S_HALT;
                end else if (tick) begin
                    if (bp_match) begin
                        bp_hit_d = 1'b1;
                        if (DRAIN_DEPTH == 0) begin
                            state_d = S_HALT;
                            drain_d = '0;
                        end else begin
                            state_d = S_DRAIN;
                            drain_d = DC_W'(DRAIN_DEPTH);
                        end
                    end else begin
                        pipe_en_d = 1'b1;
                    end
                end
            end
            S_STEP: begin
                state_d = S_HALT;
            end
            S_DRAIN: begin
                // go is deliberately ignored here: older instructions must retire
                if (halt_req) begin
                    state_d = S_HALT;
                    drain_d = '0;
                end else if (tick) begin
                    pipe_en_d = 1'b1;
                    drain_d   = drain_q - DC_W'(1);
                    if (drain_q <= DC_W'(1)) begin
                        state_d        = S_HALT;
                        last_drain_adv = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        // Fetch stays frozen through the final drain advance as well
        fetch_hold_d = (state_d == S_DRAIN) | last_drain_adv;
        halted_d     = (state_d == S_HALT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_HALT;
            pipe_en_q    <= 1'b0;
            fetch_hold_q <= 1'b0;
            halted_q     <= 1'b1;
            bp_hit_q     <= 1'b0;
            skip_bp_q    <= 1'b0;
            drain_q      <= '0;
            cc_q         <= '0;
        end else begin
            state_q      <= state_d;
            pipe_en_q    <= pipe_en_d;
            fetch_hold_q <= fetch_hold_d;
            halted_q     <= halted_d;
            bp_hit_q     <= bp_hit_d;
            skip_bp_q    <= skip_bp_d;
            drain_q      <= drain_d;
            cc_q         <= cc_d;
        end
    end

    assign pipe_en    = pipe_en_q;
    assign fetch_hold = fetch_hold_q;
    assign halted     = halted_q;
    assign bp_hit     = bp_hit_q;
    assign state      = state_q;
    assign cc         = cc_q;

endmodule

// File: tb/tb_exec_controller.sv
// Randomized scoreboard bench for exec_controller: a tick-level behavioural model
// predicts every pipeline advance; a monitor matches them against pipe_en pulses.
module tb_exec_controller;

    localparam int unsigned DEPTH = 4;
    localparam int M_HALTED   = 0;
    localparam int M_RUNNING  = 1;
    localparam int M_DRAINING = 2;

    typedef struct packed {
        logic        fh;
        logic [15:0] cc;
    } exp_t;

    logic        clock, reset, go, step, tick, halt_req, bp_en;
    logic [15:0] pc, bp_addr;
    logic        pipe_en, fetch_hold, halted, bp_hit;
    logic [1:0]  state;
    logic [15:0] cc;
    logic        pc_load;
    logic [15:0] pc_load_val;

    exp_t exp_q[$];
    exp_t e;
    int   n_total, n_pass, fh_adv;

    // Behavioural model: mode, expected counter, expected PC, resume flag, drain left
    int          m_mode;
    logic [15:0] m_cc;
    logic [15:0] m_pc;
    bit          m_first;
    bit          m_hit;
    int          m_left;

    exec_controller #(.DRAIN_DEPTH(DEPTH), .CC_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .go(go), .step(step), .tick(tick),
        .halt_req(halt_req), .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en),
        .pipe_en(pipe_en), .fetch_hold(fetch_hold), .halted(halted),
        .bp_hit(bp_hit), .state(state), .cc(cc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Environment PC: advances on pipe_en unless fetch is held
    always @(posedge clock) begin
        if (pc_load) pc <= pc_load_val;
        else if (pipe_en && !fetch_hold) pc <= pc + 16'd1;
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    always @(negedge clock) begin
        if (reset && pipe_en) begin
            if (fetch_hold) fh_adv++;
            if (exp_q.size() == 0) begin
                chk("unexpected_pipe_en", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("advance_fh_cc", 32'({fetch_hold, cc}), 32'(e));
            end
        end
    end

    function automatic void advance(logic fh);
        exp_q.push_back({fh, m_cc});
        m_cc = m_cc + 16'd1;
    endfunction

    function automatic void model_resume();
        m_mode  = M_RUNNING;
        m_first = 1'b1;
        m_hit   = 1'b0;
    endfunction

    function automatic void stop_after_bp();
        m_mode = M_HALTED;
        if (go) model_resume();
    endfunction

    function automatic void model_tick(bit halt);
        if (m_mode == M_RUNNING) begin
            if (halt) m_mode = M_HALTED;
            else if (bp_en && m_pc == bp_addr && !m_first) begin
                m_hit  = 1'b1;
                m_left = DEPTH;
                if (DEPTH == 0) stop_after_bp();
                else m_mode = M_DRAINING;
            end else begin
                advance(1'b0);
                m_pc    = m_pc + 16'd1;
                m_first = 1'b0;
            end
        end else if (m_mode == M_DRAINING) begin
            if (halt) m_mode = M_HALTED;
            else begin
                advance(1'b1);
                m_left--;
                if (m_left == 0) stop_after_bp();
            end
        end
    endfunction

    function automatic logic [1:0] mode_code();
        if (m_mode == M_RUNNING) return 2'd1;
        if (m_mode == M_DRAINING) return 2'd3;
        return 2'd0;
    endfunction

    task automatic tick_once(bit halt);
        @(negedge clock);
        tick = 1'b1; halt_req = halt;
        if (halt) go = 1'b0;
        model_tick(halt);
        @(negedge clock);
        tick = 1'b0; halt_req = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clock);
    endtask

    task automatic do_step();
        @(negedge clock);
        step = 1'b1;
        m_hit = 1'b0;
        advance(1'b0);
        m_pc = m_pc + 16'd1;
        m_first = 1'b0;
        @(negedge clock);
        step = 1'b0;
        @(negedge clock);
        chk("step_returns_halt", 32'(state), 32'd0);
    endtask

    task automatic start_go();
        @(negedge clock);
        go = 1'b1;
        model_resume();
        @(negedge clock);
    endtask

    task automatic drop_go();
        @(negedge clock);
        go = 1'b0;
        if (m_mode == M_RUNNING) m_mode = M_HALTED;
        @(negedge clock);
    endtask

    task automatic load_pc(logic [15:0] v);
        @(negedge clock);
        pc_load = 1'b1; pc_load_val = v; m_pc = v;
        @(negedge clock);
        pc_load = 1'b0;
    endtask

    task automatic check_status(string name);
        repeat (2) @(negedge clock);
        chk({name, "_state"}, 32'(state), 32'(mode_code()));
        chk({name, "_bp_hit"}, 32'(bp_hit), 32'(m_hit));
        chk({name, "_cc"}, 32'(cc), 32'(m_cc));
        chk({name, "_halted"}, 32'(halted), 32'(m_mode == M_HALTED));
        chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic tick_until_drain();
        for (int i = 0; i < 40 && m_mode == M_RUNNING; i++) tick_once(1'b0);
    endtask

    initial begin
        int fh0;
        n_total = 0; n_pass = 0; fh_adv = 0;
        reset = 1'b0; go = 1'b0; step = 1'b0; tick = 1'b0; halt_req = 1'b0;
        bp_en = 1'b0; bp_addr = 16'h0; pc_load = 1'b0; pc_load_val = 16'h0;
        m_mode = M_HALTED; m_cc = 16'h0; m_pc = 16'h0; m_first = 1'b0;
        m_hit = 1'b0; m_left = 0;
        repeat (3) @(negedge clock);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pipe_en", 32'(pipe_en), 32'd0);
        chk("rst_fetch_hold", 32'(fetch_hold), 32'd0);
        chk("rst_halted", 32'(halted), 32'd1);
        chk("rst_bp_hit", 32'(bp_hit), 32'd0);
        chk("rst_cc", 32'(cc), 32'd0);
        reset = 1'b1;
        load_pc(16'h0000);
        for (int i = 0; i < 3; i++) tick_once(1'b0);
        check_status("idle_after_reset");

        // Three single steps spaced five cycles apart
        for (int i = 0; i < 3; i++) begin
            do_step();
            repeat (3) @(negedge clock);
        end
        chk("steps_cc", 32'(cc), 32'd3);

        // Ten free-run ticks, then halt_req on the eleventh
        load_pc(16'h0100);
        bp_en = 1'b0;
        start_go();
        for (int i = 0; i < 10; i++) tick_once(1'b0);
        tick_once(1'b1);
        check_status("run10");
        chk("run10_cc", 32'(cc), 32'd13);

        // Breakpoint at 0x0010, drain with go dropped, then resume at the breakpoint
        load_pc(16'h0008);
        bp_addr = 16'h0010; bp_en = 1'b1;
        start_go();
        tick_until_drain();
        fh0 = fh_adv;
        chk("bp_hit_set", 32'(bp_hit), 32'd1);
        drop_go();
        for (int i = 0; i < 10 && m_mode == M_DRAINING; i++) tick_once(1'b0);
        check_status("bp_drain");
        chk("bp_drain_advances", 32'(fh_adv - fh0), 32'(DEPTH));
        chk("bp_pc_frozen", 32'(pc), 32'h10);
        start_go();
        for (int i = 0; i < 5; i++) tick_once(1'b0);
        check_status("bp_resume");
        chk("bp_resume_pc", 32'(pc), 32'h15);
        drop_go();

        // halt_req aborts a drain part way
        load_pc(16'h0020);
        bp_addr = 16'h0022;
        start_go();
        tick_until_drain();
        tick_once(1'b0);
        tick_once(1'b1);
        check_status("drain_abort");

        // go and step together from HALT: run wins, no step pulse
        @(negedge clock);
        go = 1'b1; step = 1'b1;
        model_resume();
        @(negedge clock);
        step = 1'b0;
        chk("go_step_state", 32'(state), 32'd1);
        check_status("go_step");
        drop_go();

        // Randomized mix of steps, runs, ticks, halts and breakpoints
        for (int it = 0; it < 250; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (m_mode == M_HALTED) begin
                if (r < 3) do_step();
                else if (r < 5) begin
                    load_pc(16'($urandom_range(0, 15)));
                    bp_en = 1'($urandom_range(0, 1));
                    bp_addr = m_pc + 16'($urandom_range(0, 6));
                end else start_go();
            end else if (m_mode == M_RUNNING) begin
                if (r == 0) drop_go();
                else tick_once(r == 1);
            end else begin
                if (r == 0) drop_go();
                else tick_once(r == 1);
            end
            if (it % 25 == 24) check_status("random");
        end
        if (m_mode == M_DRAINING) tick_once(1'b1);
        if (m_mode == M_RUNNING) drop_go();
        check_status("random_end");

        // Reset mid-drain: everything back to reset values at once, then idle
        load_pc(16'h0040);
        bp_addr = 16'h0041; bp_en = 1'b1;
        start_go();
        tick_until_drain();
        tick_once(1'b0);
        tick_once(1'b0);
        @(negedge clock);
        reset = 1'b0; go = 1'b0;
        #1;
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_pipe_en", 32'(pipe_en), 32'd0);
        chk("mid_rst_fetch_hold", 32'(fetch_hold), 32'd0);
        chk("mid_rst_halted", 32'(halted), 32'd1);
        chk("mid_rst_bp_hit", 32'(bp_hit), 32'd0);
        chk("mid_rst_cc", 32'(cc), 32'd0);
        exp_q.delete();
        m_cc = 16'h0; m_mode = M_HALTED; m_hit = 1'b0; m_first = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) tick_once(1'b0);
        check_status("after_rst_idle");

        // Counter wrap: 65535 back-to-back advances, then one step
        load_pc(16'h0000);
        bp_en = 1'b0;
        start_go();
        for (int i = 0; i < 65535; i++) begin
            @(negedge clock);
            tick = 1'b1;
            advance(1'b0);
        end
        @(negedge clock);
        tick = 1'b0; go = 1'b0;
        m_mode = M_HALTED;
        repeat (2) @(negedge clock);
        chk("cc_full", 32'(cc), 32'hFFFF);
        do_step();
        chk("cc_wrap", 32'(cc), 32'h0000);
        check_status("final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
